// File: rtl/arb_rr8.sv
// rtl/arb_rr8.sv - eight-way round-robin arbiter with optional hold timeout
module arb_rr8 #(
    parameter int MAX_HOLD = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // A zero MAX_HOLD disables forced release entirely.
    localparam bit         TIMEOUT_EN = (MAX_HOLD != 0);
    localparam logic [7:0] HOLD_LAST  = 8'(MAX_HOLD - 1);

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [7:0] gnt_q, gnt_d;
    logic [2:0] gnt_idx_q, gnt_idx_d;
    logic       gnt_valid_q, gnt_valid_d;
    logic       timeout_q, timeout_d;

    logic [2:0] scan_idx;
    logic [2:0] winner;
    logic       release_now;
    logic       force_now;

    // Rotating priority scan: walk downward so the smallest offset from ptr wins.
    always_comb begin
        winner   = ptr_q;
        scan_idx = ptr_q;
        for (int k = 7; k >= 0; k--) begin
            scan_idx = ptr_q + k[2:0];
            if (req[scan_idx]) begin
                winner = scan_idx;
            end
        end
    end

    // Release conditions for the current owner; a voluntary release masks the timeout.
    always_comb begin
        release_now = done || !req[gnt_idx_q];
        force_now   = TIMEOUT_EN && (hold_cnt_q == HOLD_LAST);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 3'd0;
            hold_cnt_q  <= 8'd0;
            gnt_q       <= 8'h00;
            gnt_idx_q   <= 3'd0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    // Next-state logic: grant from IDLE, release or force-release from GRANT.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d     = ST_GRANT;
                    gnt_idx_d   = winner;
                    gnt_d       = 8'h01 << winner;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = 8'd0;
                end
            end
            ST_GRANT: begin
                if (release_now || force_now) begin
                    state_d     = ST_IDLE;
                    gnt_d       = 8'h00;
                    gnt_valid_d = 1'b0;
                    ptr_d       = gnt_idx_q + 3'd1;
                    timeout_d   = !release_now;
                end else begin
                    hold_cnt_d  = hold_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs come straight from registers; no input reaches them combinationally.
    always_comb begin
        gnt       = gnt_q;
        gnt_idx   = gnt_idx_q;
        gnt_valid = gnt_valid_q;
        timeout   = timeout_q;
    end

endmodule

// File: tb/tb_arb_rr8.sv
// tb/tb_arb_rr8.sv - randomized and directed bench for arb_rr8 with reference model
module tb_arb_rr8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] req = 8'h00;
    logic       done = 1'b0;

    logic [7:0] gnt_a, gnt_b;
    logic [2:0] idx_a, idx_b;
    logic       val_a, val_b;
    logic       to_a, to_b;

    always #5 clk = ~clk;

    arb_rr8 #(.MAX_HOLD(0)) u_k0 (
        .clk(clk), .reset(reset), .req(req), .done(done),
        .gnt(gnt_a), .gnt_idx(idx_a), .gnt_valid(val_a), .timeout(to_a)
    );

    arb_rr8 #(.MAX_HOLD(4)) u_k4 (
        .clk(clk), .reset(reset), .req(req), .done(done),
        .gnt(gnt_b), .gnt_idx(idx_b), .gnt_valid(val_b), .timeout(to_b)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    // Reference model: who owns the resource, for how many visible cycles, and where the scan starts.
    int kmax    [2] = '{0, 4};
    bit m_busy  [2] = '{1'b0, 1'b0};
    int m_owner [2] = '{0, 0};
    int m_ptr   [2] = '{0, 0};
    int m_age   [2] = '{0, 0};
    bit m_to    [2] = '{1'b0, 1'b0};

    function automatic int first_req(int ptr, logic [7:0] r);
        for (int k = 0; k < 8; k++) begin
            if (r[(ptr + k) % 8]) return (ptr + k) % 8;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                m_busy[d] <= 1'b0; m_owner[d] <= 0; m_ptr[d] <= 0; m_age[d] <= 0; m_to[d] <= 1'b0;
            end else if (!m_busy[d]) begin
                m_to[d] <= 1'b0;
                if (first_req(m_ptr[d], req) >= 0) begin
                    m_busy[d]  <= 1'b1;
                    m_owner[d] <= first_req(m_ptr[d], req);
                    m_age[d]   <= 1;
                end
            end else if (done || !req[m_owner[d]]) begin
                m_busy[d] <= 1'b0; m_ptr[d] <= (m_owner[d] + 1) % 8; m_to[d] <= 1'b0;
            end else if (kmax[d] != 0 && m_age[d] == kmax[d]) begin
                m_busy[d] <= 1'b0; m_ptr[d] <= (m_owner[d] + 1) % 8; m_to[d] <= 1'b1;
            end else begin
                m_age[d] <= m_age[d] + 1; m_to[d] <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [12:0] got, input logic [12:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got gnt=%h idx=%0d valid=%b to=%b, expected gnt=%h idx=%0d valid=%b to=%b",
                     name, $time, got[12:5], got[4:2], got[1], got[0], exp[12:5], exp[4:2], exp[1], exp[0]);
        end
    endtask

    task automatic chk_lit(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
        end
    endtask

    // Every cycle after reset: both instances must match the model.
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("model_k0", {gnt_a, idx_a, val_a, to_a},
                {(m_busy[0] ? (8'h01 << m_owner[0]) : 8'h00), 3'(m_owner[0]), m_busy[0], m_to[0]});
            chk("model_k4", {gnt_b, idx_b, val_b, to_b},
                {(m_busy[1] ? (8'h01 << m_owner[1]) : 8'h00), 3'(m_owner[1]), m_busy[1], m_to[1]});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; req = 8'h00; done = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    logic [7:0] seen;
    bit         dup;

    initial begin
        // Reset with every requester active.
        reset = 1'b1; req = 8'hFF; done = 1'b0;
        tick();
        cmp_on = 1'b1;
        tick();
        chk_lit("reset_gnt_k0", gnt_a, 8'h00);
        chk_lit("reset_gnt_k4", gnt_b, 8'h00);
        reset = 1'b0;
        tick();
        chk_lit("first_gnt", gnt_a, 8'h01);
        chk_lit("first_idx", {5'd0, idx_a}, 8'd0);

        // Fairness: pulse done on every grant, order must be 1..7 then 0.
        seen = 8'h01; dup = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            done = 1'b1;
            tick();
            chk_lit("fair_release", gnt_a, 8'h00);
            done = 1'b0;
            tick();
            chk_lit("fair_order", gnt_a, 8'h01 << (i % 8));
            if (i < 8 && (seen & gnt_a) != 0) dup = 1'b1;
            seen = seen | gnt_a;
        end
        chk_lit("fair_all_seen", seen, 8'hFF);
        chk_lit("fair_no_dup", {7'd0, dup}, 8'h00);

        // Single requester, release and re-grant two cycles after done.
        do_reset();
        req = 8'h10;
        tick();
        chk_lit("single_gnt", gnt_a, 8'h10);
        chk_lit("single_idx", {5'd0, idx_a}, 8'd4);
        done = 1'b1;
        tick();
        chk_lit("single_release", gnt_a, 8'h00);
        done = 1'b0;
        tick();
        chk_lit("single_regrant", gnt_a, 8'h10);

        // Rotation skip: ptr=6 after owner 5, then req=21 must go to 0, leaving ptr=1.
        do_reset();
        req = 8'h20;
        tick();
        chk_lit("skip_gnt5", gnt_a, 8'h20);
        done = 1'b1;
        tick();
        done = 1'b0; req = 8'h21;
        tick();
        chk_lit("skip_gnt0", gnt_a, 8'h01);
        done = 1'b1;
        tick();
        done = 1'b0; req = 8'hFF;
        tick();
        chk_lit("skip_ptr1", gnt_a, 8'h02);

        // Timeout with MAX_HOLD=4 on u_k4; u_k0 keeps holding.
        do_reset();
        req = 8'h04;
        for (int j = 0; j < 4; j++) begin
            tick();
            chk_lit("to_hold", gnt_b, 8'h04);
        end
        tick();
        chk_lit("to_drop", gnt_b, 8'h00);
        chk_lit("to_pulse", {7'd0, to_b}, 8'd1);
        chk_lit("to_k0_holds", gnt_a, 8'h04);
        chk_lit("to_k0_no_pulse", {7'd0, to_a}, 8'd0);
        tick();
        chk_lit("to_regrant", gnt_b, 8'h04);
        chk_lit("to_pulse_once", {7'd0, to_b}, 8'd0);
        for (int j = 0; j < 3; j++) tick();
        done = 1'b1;
        tick();
        chk_lit("to_coincide_gnt", gnt_b, 8'h00);
        chk_lit("to_coincide_pulse", {7'd0, to_b}, 8'd0);
        done = 1'b0;

        // Reset in the middle of a grant.
        do_reset();
        req = 8'h08;
        tick();
        chk_lit("midrst_gnt", gnt_a, 8'h08);
        reset = 1'b1;
        tick();
        chk_lit("midrst_drop", gnt_a, 8'h00);
        chk_lit("midrst_no_to", {7'd0, to_b}, 8'd0);
        reset = 1'b0; req = 8'hFF;
        tick();
        chk_lit("midrst_ptr0", gnt_a, 8'h01);

        // Dropping the owner's request releases and advances ptr to 4.
        do_reset();
        req = 8'h08;
        tick();
        req = 8'hF7;
        tick();
        chk_lit("drop_release", gnt_a, 8'h00);
        tick();
        chk_lit("drop_next", gnt_a, 8'h10);
        chk_lit("drop_idx", {5'd0, idx_a}, 8'd4);

        // Randomized traffic checked cycle by cycle against the model.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0: req = 8'($urandom_range(0, 255));
                    1: req = 8'h01 << $urandom_range(0, 7);
                    2: req = 8'hFF;
                    default: req = 8'h00;
                endcase
            end
            done  = ($urandom_range(0, 5) == 0);
            reset = ($urandom_range(0, 199) == 0);
            tick();
        end

        reset = 1'b0;
        tick();
        cmp_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
